// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and byte-lane formatter sharing the data memory between
// the CPU load/store port (requester 0) and the debug/loader port (requester 1).
module dmem_arbiter #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic        last_q, last_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_owner_q, rsp_owner_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_we_q, rsp_we_d;
    logic [1:0]  rsp_off_q, rsp_off_d;
    logic [1:0]  rsp_size_q, rsp_size_d;

    logic        any_gnt;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  off;
    logic        aligned;
    logic [3:0]  lanes;
    logic        unused_addr_bits;

    logic        rsp_live;
    logic [31:0] rd_shifted;
    logic [31:0] rd_data;

    // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie.
    always_comb begin
        m0_gnt  = !rst && m0_req && (!m1_req || last_q);
        m1_gnt  = !rst && m1_req && (!m0_req || !last_q);
        any_gnt = m0_gnt || m1_gnt;
    end

    always_comb begin
        sel_we    = m1_gnt ? m1_we    : m0_we;
        sel_size  = m1_gnt ? m1_size  : m0_size;
        sel_addr  = m1_gnt ? m1_addr  : m0_addr;
        sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
        off       = sel_addr[1:0];
        case (sel_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !off[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b0;
        endcase
        case (sel_size)
            2'b00:   lanes = 4'b0001;
            2'b01:   lanes = 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    assign unused_addr_bits = ^sel_addr[31:MEM_AW+2];

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (any_gnt) begin
            mem_addr = sel_addr[MEM_AW+1:2];
            if (aligned) begin
                mem_en    = 1'b1;
                mem_we    = sel_we ? (lanes << off) : 4'b0000;
                mem_wdata = sel_wdata << {off, 3'b000};
            end
        end
    end

    always_comb begin
        last_d      = any_gnt ? m1_gnt : last_q;
        rsp_valid_d = any_gnt;
        rsp_owner_d = m1_gnt;
        rsp_err_d   = !aligned;
        rsp_we_d    = sel_we;
        rsp_off_d   = off;
        rsp_size_d  = sel_size;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_off_q   <= '0;
            rsp_size_q  <= '0;
        end else begin
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_err_q   <= rsp_err_d;
            rsp_we_q    <= rsp_we_d;
            rsp_off_q   <= rsp_off_d;
            rsp_size_q  <= rsp_size_d;
        end
    end

    // A reset arriving in the response cycle suppresses the pending response.
    always_comb begin
        rsp_live   = rsp_valid_q && !rst;
        rd_shifted = mem_rdata >> {rsp_off_q, 3'b000};
        case (rsp_size_q)
            2'b00:   rd_data = {24'h0, rd_shifted[7:0]};
            2'b01:   rd_data = {16'h0, rd_shifted[15:0]};
            default: rd_data = rd_shifted;
        endcase
        if (rsp_err_q || rsp_we_q) rd_data = '0;
        m0_rvalid = rsp_live && !rsp_owner_q;
        m1_rvalid = rsp_live && rsp_owner_q;
        m0_err    = m0_rvalid && rsp_err_q;
        m1_err    = m1_rvalid && rsp_err_q;
        m0_rdata  = m0_rvalid ? rd_data : '0;
        m1_rdata  = m1_rvalid ? rd_data : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a reference memory and arbitration model
// predict grants and lane controls; responses are checked from a scoreboard.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    dmem_arbiter #(.MEM_AW(10)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical memory driven by the DUT's lane controls.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    typedef struct {
        int          cyc;
        bit          owner;
        bit          err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] ref_mem [1024];
    bit          ptr_m = 1'b1;
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] glog = '0;
    int          gcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic        eg0, eg1, due, o, we, al;
        logic [1:0]  sz, off;
        logic [31:0] a, d, ewd, rd, word;
        logic [3:0]  ewe;
        int          nb;
        int          w;
        rsp_t        e;
        e   = '{0, 1'b0, 1'b0, 32'h0};
        eg0 = !rst && m0_req && (!m1_req || ptr_m);
        eg1 = !rst && m1_req && (!m0_req || !ptr_m);
        chk("m0_gnt", 32'(m0_gnt), 32'(eg0));
        chk("m1_gnt", 32'(m1_gnt), 32'(eg1));
        if (m0_gnt || m1_gnt) begin
            if (gcnt < 16) glog[gcnt] = m1_gnt;
            gcnt++;
        end

        due = 1'b0;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e   = q.pop_front();
            due = 1'b1;
        end
        chk("m0_rvalid", 32'(m0_rvalid), 32'(due && !rst && !e.owner));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(due && !rst && e.owner));
        chk("m0_err", 32'(m0_err), 32'(due && !rst && !e.owner && e.err));
        chk("m1_err", 32'(m1_err), 32'(due && !rst && e.owner && e.err));
        chk("m0_rdata", m0_rdata, (due && !rst && !e.owner) ? e.rdata : 32'h0);
        chk("m1_rdata", m1_rdata, (due && !rst && e.owner) ? e.rdata : 32'h0);

        if (eg0 || eg1) begin
            o   = eg1;
            we  = o ? m1_we    : m0_we;
            sz  = o ? m1_size  : m0_size;
            a   = o ? m1_addr  : m0_addr;
            d   = o ? m1_wdata : m0_wdata;
            off = a[1:0];
            nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            al  = (sz == 2'b00) || (sz == 2'b01 && !off[0]) || (sz == 2'b10 && off == 2'b00);
            w   = int'(a[11:2]);
            ewe = 4'b0000;
            for (int b = 0; b < 4; b++)
                if (al && we && b >= int'(off) && b < int'(off) + nb) ewe[b] = 1'b1;
            ewd = d << (8 * int'(off));
            chk("mem_en", 32'(mem_en), 32'(al));
            chk("mem_we", 32'(mem_we), 32'(ewe));
            if (al) begin
                chk("mem_addr", 32'(mem_addr), 32'(a[11:2]));
                chk("mem_wdata", mem_wdata, ewd);
            end
            rd = 32'h0;
            if (al && !we) begin
                word = ref_mem[w];
                rd   = word >> (8 * int'(off));
                if (nb == 1) rd = rd & 32'h0000_00FF;
                if (nb == 2) rd = rd & 32'h0000_FFFF;
            end
            for (int b = 0; b < 4; b++)
                if (ewe[b]) ref_mem[w][8*b +: 8] = ewd[8*b +: 8];
            q.push_back('{cyc + 1, o, !al, rd});
            ptr_m = o;
        end else begin
            chk("mem_en_idle", 32'(mem_en), 32'h0);
            chk("mem_we_idle", 32'(mem_we), 32'h0);
            chk("mem_addr_idle", 32'(mem_addr), 32'h0);
            chk("mem_wdata_idle", mem_wdata, 32'h0);
        end
        if (rst) ptr_m = 1'b1;
    endtask

    task automatic tick();
        #4;
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set0(input logic r, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
        m0_req = r; m0_we = we; m0_size = sz; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set1(input logic r, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
        m1_req = r; m1_we = we; m1_size = sz; m1_addr = a; m1_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        rst = 1'b1;
        set0(1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
        set1(1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        repeat (3) tick();
        rst = 1'b0;
        set0(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        set1(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        tick();

        set0(1'b1, 1'b1, 2'b10, 32'h4, 32'h9ABC_DEF0); tick();
        set0(1'b1, 1'b0, 2'b10, 32'h4, 32'h0);         tick();
        set0(1'b1, 1'b1, 2'b00, 32'h7, 32'h0000_0055); tick();
        set0(1'b1, 1'b1, 2'b01, 32'h6, 32'h0000_1234); tick();
        set0(1'b1, 1'b0, 2'b01, 32'h6, 32'h0);         tick();
        set0(1'b1, 1'b0, 2'b00, 32'h4, 32'h0);         tick();
        set0(1'b1, 1'b0, 2'b00, 32'h5, 32'h0);         tick();
        set0(1'b1, 1'b0, 2'b10, 32'h1004, 32'h0);      tick();
        set0(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        set1(1'b1, 1'b1, 2'b10, 32'h10, 32'hCAFE_F00D); tick();
        set1(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);         tick();
        set1(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);

        set0(1'b1, 1'b0, 2'b10, 32'h2, 32'h0);         tick();
        set0(1'b1, 1'b0, 2'b01, 32'h3, 32'h0);         tick();
        set0(1'b1, 1'b1, 2'b11, 32'h0, 32'hFFFF_FFFF); tick();
        set0(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);         tick();

        rst = 1'b1; tick();
        rst = 1'b0;
        glog = '0;
        gcnt = 0;
        set0(1'b1, 1'b0, 2'b10, 32'h4, 32'h0);
        set1(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        repeat (6) tick();
        chk("rr_alternate", 32'(glog[5:0]), 32'b101010);
        set0(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        repeat (2) tick();
        set0(1'b1, 1'b0, 2'b10, 32'h4, 32'h0);
        tick();
        chk("rr_after_m1_only", 32'(glog[8:6]), 32'b011);

        set1(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        set0(1'b1, 1'b0, 2'b10, 32'h4, 32'h0); tick();
        set0(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        rst = 1'b1; tick();
        rst = 1'b0;
        set0(1'b1, 1'b0, 2'b10, 32'h4, 32'h0);
        set1(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        tick();
        chk("rr_after_reset", 32'(glog[10:9]), 32'b00);
        set0(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        set1(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        repeat (2) tick();
        chk("scoreboard_empty", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and lane formatter in front of the byte-lane data memory (four 8-bit banks, one word per address). It shares the memory between the CPU load/store port (requester 0) and the debug/loader port (requester 1). It grants at most one access per cycle using round-robin, converts byte/half/word accesses into lane write enables and shifted data, and returns read data one cycle after grant. Misaligned accesses are rejected with an error response.

## Interface
- MEM_AW, 10: word-address width of the data memory (depth 2^MEM_AW words)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- m0_req, m1_req  in  1  access request, held until granted
- m0_we, m1_we  in  1  1 = store, 0 = load
- m0_size, m1_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  store data, right-justified
- m0_gnt, m1_gnt  out  1  combinational grant, same cycle as request
- m0_rvalid, m1_rvalid  out  1  one-cycle response pulse, for loads and stores
- m0_rdata, m1_rdata  out  32  load data, right-justified and zero-extended
- m0_err, m1_err  out  1  valid with rvalid; access was misaligned or illegal
- mem_en  out  1  memory access strobe
- mem_we  out  4  byte-lane write enables; bit i drives bank i
- mem_addr  out  MEM_AW  word address, addr[MEM_AW+1:2]
- mem_wdata  out  32  lane-positioned store data
- mem_rdata  in  32  memory read word, valid one cycle after mem_en

## Operation
- Arbitration:
  - If only one request is active, that requester is granted.
  - If both are active, the requester that was not granted last wins.
  - The last-grant pointer updates only on a cycle with a grant.
  - After reset the pointer is 1, so requester 0 wins the first contention.
- Alignment check, with off = addr[1:0]:
  - Byte: always aligned.
  - Half: aligned when off[0] = 0.
  - Word: aligned when off = 00.
  - size = 11: always misaligned.
- Aligned grant:
  - mem_en = 1.
  - For stores, mem_we = lane mask shifted left by off. The lane mask is 0001 for byte, 0011 for half, 1111 for word. For loads, mem_we = 0000.
  - mem_wdata = wdata << (8*off).
- Misaligned grant:
  - The request is still granted and consumed.
  - mem_en = 0 and mem_we = 0000.
  - The response next cycle has err = 1 and rdata = 0.
- No grant: mem_en = 0, mem_we = 0000, mem_addr and mem_wdata = 0.
- Response register captures, at each grant: owner, err, off, size, and a valid bit.
- Response cycle:
  - Only the owner's rvalid pulses; the other requester's rvalid stays 0.
  - For a load, rdata = (mem_rdata >> 8*off) masked to 8, 16 or 32 bits.
  - For a store or an error, rdata = 0.
  - Sign extension is the requester's job.
  - A non-owner's rdata is 0.

## Timing
- Reset values: all gnt, rvalid and err are 0; all rdata are 0; mem_en = 0, mem_we = 0; pointer = 1; response valid = 0.
- Grant latency: 0 cycles, since gnt is combinational from req and the pointer.
- Response latency: exactly 1 cycle after the grant edge.
- Throughput: one access per cycle. Back-to-back grants are allowed, and a response and a new grant may occur in the same cycle.
- A requester that is not granted must hold req, we, size, addr and wdata stable until granted.
- Simultaneous requests: exactly one gnt is high. The loser is granted on the next cycle if it still requests.
- A requester may request again in the cycle its response arrives. Under contention, round-robin forces alternation.
- Reset with an access in flight: the pending response is discarded (no rvalid), and the pointer returns to 1.
- rst takes precedence over any request in that cycle: no grant, mem_en = 0.
- Address bits above MEM_AW+1 are ignored, so accesses wrap modulo the memory size.

## Test plan
- **Reset:** hold rst with both req = 1 → both gnt = 0, mem_en = 0, no rvalid, for the full reset duration.
- **Word store then load, requester 0 only:**
  - Store 0x9ABCDEF0 to addr 0x4 → mem_we = 1111, mem_addr = 1, rvalid next cycle with err = 0.
  - Load addr 0x4 → m0_rdata = 0x9ABCDEF0 one cycle after grant.
- **Byte and half lanes:**
  - sb 0x55 at addr 0x7 → mem_we = 1000, mem_wdata = 0x55000000.
  - sh 0x1234 at addr 0x6 → mem_we = 1100, mem_wdata = 0x12340000.
  - lh at 0x6 with mem_rdata = 0x12345678 → rdata = 0x00001234.
- **Misaligned:**
  - Word at 0x2, half at 0x3, size 11 → gnt = 1, mem_en = 0, mem_we = 0000, next cycle rvalid = 1, err = 1, rdata = 0.
- **Contention:**
  - Both request continuously for 6 cycles after reset → grants go 0,1,0,1,0,1.
  - Only requester 1 requests for 2 cycles → granted both cycles, then requester 0 wins the next contention.
- **Reset mid-operation:** assert rst the cycle after a load grant → no rvalid, and the next contention grants requester 0.
